// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding, bank-index width, address-width helper and 4:4:4 colours for the frame buffer
package fb_pkg;
    typedef enum logic [1:0] {DRAW, PEND, CLEAR} fb_state_e;
    localparam int BANK_W = 2;
    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOR_RED   = 12'hF00;
    localparam logic [11:0] COLOR_GREEN = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE  = 12'h00F;
    function automatic int addr_w(input int row_w, input int col_w);
        return row_w + col_w;
    endfunction
endpackage

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: simple dual-port synchronous RAM, one write and one registered read per cycle
module fb_bank_ram #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // only the output register is reset; array contents survive reset
    always_ff @(posedge clk) begin
        rdata <= !rst ? '0 : mem[raddr];
    end
endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: 2/3-bank tear-free frame buffer between tracer and VGA scanner
// Banks swap only at vertical-blank start; the new back bank is optionally cleared.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int              ROW_W       = 6,
    parameter int              COL_W       = 7,
    parameter int              PIX_W       = 12,
    parameter int              BANKS       = 2,
    parameter bit              CLEAR_EN    = 1'b1,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = PIX_W'(COLOR_BLACK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             frame_done,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_data,
    input  logic             vsync_edge,
    output logic [1:0]       front_idx,
    output logic [1:0]       back_idx,
    output logic [15:0]      frame_count,
    output logic [7:0]       drop_count
);
    localparam int AW = addr_w(ROW_W, COL_W);
    localparam logic [AW-1:0] CLR_LAST = '1;
    typedef logic [BANK_W-1:0] bank_t;

    fb_state_e state, state_n;
    bank_t front, back, spare, front_n, back_n, spare_n;
    logic ready_valid, ready_valid_n, fc_inc, drop_inc;
    logic [AW-1:0] clr_cnt;
    logic ram_we;
    logic [BANK_W+AW-1:0] ram_waddr;
    logic [PIX_W-1:0] ram_wdata;

    always_comb begin
        state_n       = state;
        front_n       = front;
        back_n        = back;
        spare_n       = spare;
        ready_valid_n = ready_valid;
        fc_inc        = 1'b0;
        drop_inc      = 1'b0;
        if (BANKS == 3) begin
            // vblank is applied first so a coincident frame_done sees post-swap roles
            if (vsync_edge && ready_valid) begin
                front_n       = spare;
                spare_n       = front;
                ready_valid_n = 1'b0;
                fc_inc        = 1'b1;
            end
            if (frame_done && state == DRAW) begin
                back_n        = spare_n;
                spare_n       = back;
                drop_inc      = ready_valid_n;
                ready_valid_n = 1'b1;
                state_n       = CLEAR_EN ? CLEAR : DRAW;
            end
        end else if (state == DRAW && frame_done) begin
            state_n = PEND;
        end else if (state == PEND && vsync_edge) begin
            front_n = back;
            back_n  = front;
            fc_inc  = 1'b1;
            state_n = CLEAR_EN ? CLEAR : DRAW;
        end
        if (state == CLEAR && clr_cnt == CLR_LAST) state_n = DRAW;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= CLEAR_EN ? CLEAR : DRAW;
            front       <= 2'd0;
            back        <= 2'd1;
            spare       <= 2'd2;
            ready_valid <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
            clr_cnt     <= '0;
        end else begin
            state       <= state_n;
            front       <= front_n;
            back        <= back_n;
            spare       <= spare_n;
            ready_valid <= ready_valid_n;
            frame_count <= frame_count + 16'(fc_inc);
            drop_count  <= drop_count + 8'(drop_inc && drop_count != 8'hFF);
            clr_cnt     <= state == CLEAR ? clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (front != back && front != spare && back != spare);
    end

    assign wr_ready    = state == DRAW;
    assign front_idx   = front;
    assign back_idx    = back;
    assign ram_we      = rst && (state == CLEAR || (wr_en && wr_ready));
    assign ram_waddr   = state == CLEAR ? {back, clr_cnt} : {back, wr_col, wr_row};
    assign ram_wdata   = state == CLEAR ? CLEAR_COLOR : wr_data;

    fb_bank_ram #(
        .AW(BANK_W + AW),
        .DW(PIX_W),
        .DEPTH(BANKS << AW)
    ) u_ram (
        .clk(clk),
        .rst(rst),
        .we(ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr({front, rd_col, rd_row}),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: directed bench for a 2-bank clearing instance and a 3-bank non-clearing instance
module tb_frame_buffer_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst = 1'b0, a_wr_en = 1'b0, a_fd = 1'b0, a_v = 1'b0;
    logic [5:0]  a_wr_row = '0, a_rd_row = '0;
    logic [6:0]  a_wr_col = '0, a_rd_col = '0;
    logic [11:0] a_wr_data = '0, a_rd_data;
    logic        a_wr_ready;
    logic [1:0]  a_front, a_back;
    logic [15:0] a_fc;
    logic [7:0]  a_dc;

    logic        b_rst = 1'b0, b_wr_en = 1'b0, b_fd = 1'b0, b_v = 1'b0;
    logic [5:0]  b_wr_row = '0, b_rd_row = '0;
    logic [6:0]  b_wr_col = '0, b_rd_col = '0;
    logic [11:0] b_wr_data = '0, b_rd_data;
    logic        b_wr_ready;
    logic [1:0]  b_front, b_back;
    logic [15:0] b_fc;
    logic [7:0]  b_dc;

    frame_buffer_ctrl #(.BANKS(2), .CLEAR_EN(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_col(a_wr_col),
        .wr_data(a_wr_data), .frame_done(a_fd), .wr_ready(a_wr_ready), .rd_row(a_rd_row),
        .rd_col(a_rd_col), .rd_data(a_rd_data), .vsync_edge(a_v), .front_idx(a_front),
        .back_idx(a_back), .frame_count(a_fc), .drop_count(a_dc)
    );

    frame_buffer_ctrl #(.BANKS(3), .CLEAR_EN(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col),
        .wr_data(b_wr_data), .frame_done(b_fd), .wr_ready(b_wr_ready), .rd_row(b_rd_row),
        .rd_col(b_rd_col), .rd_data(b_rd_data), .vsync_edge(b_v), .front_idx(b_front),
        .back_idx(b_back), .frame_count(b_fc), .drop_count(b_dc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        while (!a_wr_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic        v, fd, we;
        logic [11:0] data;
        logic [1:0]  f, b;
        logic [15:0] fc;
        logic [7:0]  dc;
        logic        rd_chk;
        logic [11:0] rd;
    } vec_t;
    vec_t vt[11];

    initial begin
        int n, bad;
        logic m_rv;
        logic [15:0] m_fc;
        logic [7:0] m_dc;
        vt[0]  = '{1'b0, 1'b0, 1'b1, 12'hA01, 2'd0, 2'd1, 16'd0, 8'd0, 1'b0, 12'h000};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 2'd2, 16'd0, 8'd0, 1'b0, 12'h000};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 12'hA02, 2'd0, 2'd2, 16'd0, 8'd0, 1'b0, 12'h000};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 2'd1, 16'd0, 8'd1, 1'b0, 12'h000};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 12'hA03, 2'd0, 2'd1, 16'd0, 8'd1, 1'b0, 12'h000};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 12'h000, 2'd0, 2'd2, 16'd0, 8'd2, 1'b0, 12'h000};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 2'd1, 2'd2, 16'd1, 8'd2, 1'b0, 12'h000};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 2'd1, 2'd2, 16'd1, 8'd2, 1'b1, 12'hA03};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 12'hA04, 2'd1, 2'd0, 16'd1, 8'd2, 1'b1, 12'hA03};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 12'h000, 2'd2, 2'd1, 16'd2, 8'd2, 1'b1, 12'hA03};
        vt[10] = '{1'b1, 1'b0, 1'b0, 12'h000, 2'd0, 2'd1, 16'd3, 8'd2, 1'b1, 12'hA04};

        repeat (3) @(negedge clk);
        chk("a_reset_ready", a_wr_ready, 0);
        chk("a_reset_front", a_front, 0);
        chk("a_reset_back", a_back, 1);
        chk("a_reset_fc", a_fc, 0);
        chk("b_reset_ready", b_wr_ready, 1);
        chk("b_reset_dc", b_dc, 0);
        chk("b_reset_rd", b_rd_data, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        n = 0;
        a_wr_row = '0; a_wr_col = '0; a_wr_data = 12'hFFF;
        while (!a_wr_ready && n < 10000) begin
            a_wr_en = (n == 100);
            @(negedge clk);
            n++;
        end
        a_wr_en = 1'b0;
        chk("a_clear_cycles", n, 8192);

        a_wr_row = 6'd3; a_wr_col = 7'd5; a_wr_data = 12'hF00; a_wr_en = 1'b1;
        @(negedge clk);
        a_wr_en = 1'b0; a_fd = 1'b1;
        @(negedge clk);
        a_fd = 1'b0;
        chk("a_pend_ready", a_wr_ready, 0);
        a_wr_row = '0; a_wr_col = '0; a_wr_data = 12'hFFF; a_wr_en = 1'b1;
        repeat (10) @(negedge clk);
        a_wr_en = 1'b0;
        chk("a_pend_ready_hold", a_wr_ready, 0);
        chk("a_pend_front", a_front, 0);
        a_v = 1'b1;
        @(negedge clk);
        a_v = 1'b0;
        chk("a_swap_front", a_front, 1);
        chk("a_swap_back", a_back, 0);
        chk("a_swap_fc", a_fc, 1);
        chk("a_swap_clear_ready", a_wr_ready, 0);
        a_rd_row = 6'd3; a_rd_col = 7'd5;
        @(negedge clk);
        chk("a_read_3_5", a_rd_data, 12'hF00);

        bad = 0;
        for (int i = 0; i < 8192; i++) begin
            {a_rd_col, a_rd_row} = 13'(i);
            @(negedge clk);
            if (a_rd_data !== ((i == 323) ? 12'hF00 : 12'h000)) bad++;
        end
        chk("a_clear_sweep_bad", bad, 0);
        wait_ready_a(n);
        chk("a_clear2_done", a_wr_ready, 1);

        a_fd = 1'b1; a_v = 1'b1;
        @(negedge clk);
        a_fd = 1'b0; a_v = 1'b0;
        chk("a_coinc_front", a_front, 1);
        chk("a_coinc_pend", a_wr_ready, 0);
        chk("a_coinc_fc", a_fc, 1);
        a_v = 1'b1;
        @(negedge clk);
        a_v = 1'b0;
        chk("a_coinc_swap_front", a_front, 0);
        chk("a_coinc_swap_back", a_back, 1);
        chk("a_coinc_swap_fc", a_fc, 2);

        a_fd = 1'b1;
        @(negedge clk);
        a_fd = 1'b0;
        wait_ready_a(n);
        chk("a_clear3_cycles", n + 1, 8192);
        a_v = 1'b1;
        @(negedge clk);
        a_v = 1'b0;
        chk("a_fd_in_clear_front", a_front, 0);
        chk("a_vsync_draw_fc", a_fc, 2);
        chk("a_vsync_draw_ready", a_wr_ready, 1);

        a_fd = 1'b1;
        @(negedge clk);
        a_fd = 1'b0; a_v = 1'b1;
        @(negedge clk);
        a_v = 1'b0;
        chk("a_pre_reset_front", a_front, 1);
        repeat (20) @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        chk("a_midclear_reset_front", a_front, 0);
        chk("a_midclear_reset_back", a_back, 1);
        chk("a_midclear_reset_fc", a_fc, 0);
        wait_ready_a(n);
        chk("a_midclear_restart_cycles", n, 8192);

        b_rd_row = 6'd3; b_rd_col = 7'd5; b_wr_row = 6'd3; b_wr_col = 7'd5;
        for (int i = 0; i < 11; i++) begin
            b_v = vt[i].v; b_fd = vt[i].fd; b_wr_en = vt[i].we; b_wr_data = vt[i].data;
            @(negedge clk);
            chk($sformatf("b_vec%0d_front", i), b_front, vt[i].f);
            chk($sformatf("b_vec%0d_back", i), b_back, vt[i].b);
            chk($sformatf("b_vec%0d_fc", i), b_fc, vt[i].fc);
            chk($sformatf("b_vec%0d_dc", i), b_dc, vt[i].dc);
            chk($sformatf("b_vec%0d_ready", i), b_wr_ready, 1);
            if (vt[i].rd_chk) chk($sformatf("b_vec%0d_rd", i), b_rd_data, vt[i].rd);
        end
        b_v = 1'b0; b_fd = 1'b0; b_wr_en = 1'b0;

        m_rv = 1'b0; m_fc = 16'd3; m_dc = 8'd2; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            b_fd = 1'($urandom_range(0, 1));
            b_v = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (b_v && m_rv) begin
                m_fc++;
                m_rv = 1'b0;
            end
            if (b_fd) begin
                if (m_rv && m_dc != 8'hFF) m_dc++;
                m_rv = 1'b1;
            end
            if (b_front == b_back || b_front > 2'd2 || b_back > 2'd2 || !b_wr_ready) bad++;
        end
        b_fd = 1'b0; b_v = 1'b0;
        chk("b_random_roles_bad", bad, 0);
        chk("b_random_fc", b_fc, m_fc);
        chk("b_random_dc", b_dc, m_dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
